// File: rtl/mmu_arbiter_if.sv
// mmu_arbiter_if: pipeline IF/MEM ports and memory-controller channel of the MMU arbiter.
interface mmu_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_inst;
    logic              mem_rreq;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wreq;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdone;
    logic              busy;
    logic [1:0]        mc_rw_flag;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_write_data;
    logic [MASK_W-1:0] mc_write_mask;
    logic [DATA_W-1:0] mc_read_data;
    logic              mc_busy;
    logic              mc_done;

    modport slave (
        input  if_req, if_addr, mem_rreq, mem_raddr, mem_wreq, mem_waddr, mem_wmask, mem_wdata,
        input  mc_read_data, mc_busy, mc_done,
        output if_valid, if_inst, mem_rvalid, mem_rdata, mem_wdone, busy,
        output mc_rw_flag, mc_addr, mc_write_data, mc_write_mask
    );

    modport master (
        output if_req, if_addr, mem_rreq, mem_raddr, mem_wreq, mem_waddr, mem_wmask, mem_wdata,
        output mc_read_data, mc_busy, mc_done,
        input  if_valid, if_inst, mem_rvalid, mem_rdata, mem_wdone, busy,
        input  mc_rw_flag, mc_addr, mc_write_data, mc_write_mask
    );
endinterface

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: arbitrates IF fetch and MEM read/write onto one memory-controller channel,
// one transaction at a time through IDLE -> ISSUE -> WAIT -> RESP.
module mmu_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 0
) (
    input logic clk,
    input logic rst,
    mmu_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [1:0] SRC_IF = 2'd0;
    localparam logic [1:0] SRC_RD = 2'd1;
    localparam logic [1:0] SRC_WR = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    logic [1:0]        r_owner;
    logic [1:0]        r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_if_valid;
    logic              r_mem_rvalid;
    logic              r_mem_wdone;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_mem_rdata;

    logic [3:0]        w_req;
    logic              w_any;
    logic [1:0]        w_p1;
    logic [1:0]        w_p2;
    logic [1:0]        w_gnt;
    logic [1:0]        w_gnt_nxt;
    logic [ADDR_W-1:0] w_gnt_addr;

    assign w_req      = {1'b0, bus.mem_wreq, bus.mem_rreq, bus.if_req};
    assign w_any      = |w_req;
    assign w_p1       = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    assign w_p2       = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
    // Round-robin scans IF -> RD -> WR starting at the pointer; fixed mode ignores the pointer.
    assign w_gnt      = (RR_MODE != 0)
                      ? (w_req[r_ptr] ? r_ptr : w_req[w_p1] ? w_p1 : w_p2)
                      : (bus.mem_wreq ? SRC_WR : bus.mem_rreq ? SRC_RD : SRC_IF);
    assign w_gnt_nxt  = (w_gnt == 2'd2) ? 2'd0 : w_gnt + 2'd1;
    assign w_gnt_addr = (w_gnt == SRC_WR) ? bus.mem_waddr
                      : (w_gnt == SRC_RD) ? bus.mem_raddr : bus.if_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= SRC_IF;
            r_ptr        <= SRC_IF;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_if_valid   <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_mem_wdone  <= 1'b0;
            r_if_inst    <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_if_valid   <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_mem_wdone  <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_state <= ISSUE;
                    r_owner <= w_gnt;
                    r_ptr   <= w_gnt_nxt;
                    r_addr  <= w_gnt_addr;
                    r_wdata <= (w_gnt == SRC_WR) ? bus.mem_wdata : '0;
                    r_wmask <= (w_gnt == SRC_WR) ? bus.mem_wmask : '0;
                end
                ISSUE: if (!bus.mc_busy) r_state <= WAIT;
                WAIT: if (bus.mc_done) begin
                    // Bus drops to zero here so mc_* is only non-zero in ISSUE/WAIT.
                    r_state      <= RESP;
                    r_addr       <= '0;
                    r_wdata      <= '0;
                    r_wmask      <= '0;
                    r_if_valid   <= (r_owner == SRC_IF);
                    r_mem_rvalid <= (r_owner == SRC_RD);
                    r_mem_wdone  <= (r_owner == SRC_WR);
                    if (r_owner == SRC_IF) r_if_inst <= bus.mc_read_data;
                    if (r_owner == SRC_RD) r_mem_rdata <= bus.mc_read_data;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mc_rw_flag    = (r_state == ISSUE && !bus.mc_busy)
                             ? ((r_owner == SRC_WR) ? 2'b10 : 2'b01) : 2'b00;
    assign bus.mc_addr       = r_addr;
    assign bus.mc_write_data = r_wdata;
    assign bus.mc_write_mask = r_wmask;
    assign bus.busy          = (r_state != IDLE);
    assign bus.if_valid      = r_if_valid;
    assign bus.if_inst       = r_if_inst;
    assign bus.mem_rvalid    = r_mem_rvalid;
    assign bus.mem_rdata     = r_mem_rdata;
    assign bus.mem_wdone     = r_mem_wdone;
endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: directed checks of both arbitration modes; sel picks which instance is observed.
module tb_mmu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        if_req = 1'b0, mem_rreq = 1'b0, mem_wreq = 1'b0;
    logic [31:0] if_addr = '0, mem_raddr = '0, mem_waddr = '0, mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mc_read_data = '0;
    logic        mc_busy = 1'b0, mc_done = 1'b0;
    logic        o_ivalid, o_rvalid, o_wdone, o_busy;
    logic [31:0] o_inst, o_rdata, o_addr, o_wdat;
    logic [3:0]  o_wmsk;
    logic [1:0]  o_flag;
    int          n_tests = 0;
    int          n_fail  = 0;

    mmu_arbiter_if #(.ADDR_W(32), .DATA_W(32)) f0 ();
    mmu_arbiter_if #(.ADDR_W(32), .DATA_W(32)) f1 ();

    mmu_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(0)) u_fix (.clk(clk), .rst(rst), .bus(f0.slave));
    mmu_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(f1.slave));

    assign f0.if_req = if_req;         assign f1.if_req = if_req;
    assign f0.if_addr = if_addr;       assign f1.if_addr = if_addr;
    assign f0.mem_rreq = mem_rreq;     assign f1.mem_rreq = mem_rreq;
    assign f0.mem_raddr = mem_raddr;   assign f1.mem_raddr = mem_raddr;
    assign f0.mem_wreq = mem_wreq;     assign f1.mem_wreq = mem_wreq;
    assign f0.mem_waddr = mem_waddr;   assign f1.mem_waddr = mem_waddr;
    assign f0.mem_wmask = mem_wmask;   assign f1.mem_wmask = mem_wmask;
    assign f0.mem_wdata = mem_wdata;   assign f1.mem_wdata = mem_wdata;
    assign f0.mc_read_data = mc_read_data; assign f1.mc_read_data = mc_read_data;
    assign f0.mc_busy = mc_busy;       assign f1.mc_busy = mc_busy;
    assign f0.mc_done = mc_done;       assign f1.mc_done = mc_done;

    assign o_ivalid = sel ? f1.if_valid      : f0.if_valid;
    assign o_inst   = sel ? f1.if_inst       : f0.if_inst;
    assign o_rvalid = sel ? f1.mem_rvalid    : f0.mem_rvalid;
    assign o_rdata  = sel ? f1.mem_rdata     : f0.mem_rdata;
    assign o_wdone  = sel ? f1.mem_wdone     : f0.mem_wdone;
    assign o_busy   = sel ? f1.busy          : f0.busy;
    assign o_flag   = sel ? f1.mc_rw_flag    : f0.mc_rw_flag;
    assign o_addr   = sel ? f1.mc_addr       : f0.mc_addr;
    assign o_wdat   = sel ? f1.mc_write_data : f0.mc_write_data;
    assign o_wmsk   = sel ? f1.mc_write_mask : f0.mc_write_mask;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        if_req = 0; mem_rreq = 0; mem_wreq = 0; mc_busy = 0; mc_done = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Walks one transaction from the IDLE cycle in which a request is pending through to the next IDLE.
    task automatic serve(input logic [31:0] rdata, input bit drop,
                         output logic [1:0] flag, output logic [31:0] addr, output logic [31:0] wdat,
                         output logic [2:0] pulse, output logic [31:0] data);
        tick();
        flag = o_flag; addr = o_addr; wdat = o_wdat;
        tick();
        mc_done = 1; mc_read_data = rdata;
        tick();
        mc_done = 0;
        pulse = {o_wdone, o_rvalid, o_ivalid};
        data  = pulse[0] ? o_inst : o_rdata;
        if (drop) begin
            if (pulse[0]) if_req = 0;
            if (pulse[1]) mem_rreq = 0;
            if (pulse[2]) mem_wreq = 0;
        end
        tick();
    endtask

    task automatic test_reset();
        sel = 0;
        apply_reset();
        n_tests++;
        if ({o_busy, o_flag, o_ivalid, o_rvalid, o_wdone} !== 6'b0 || o_addr !== 0 || o_inst !== 0 || o_rdata !== 0) begin
            n_fail++;
            $display("FAIL reset: busy=%b flag=%b addr=%h inst=%h rdata=%h, want all 0", o_busy, o_flag, o_addr, o_inst, o_rdata);
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h100;
        #1;
        n_tests++;
        if (o_flag !== 2'b00) begin n_fail++; $display("FAIL fetch_c0_flag: got %b want 00", o_flag); end
        tick();
        n_tests++;
        if (o_flag !== 2'b01 || o_addr !== 32'h100) begin
            n_fail++; $display("FAIL fetch_c1_cmd: flag=%b addr=%h want 01/00000100", o_flag, o_addr);
        end
        tick();
        n_tests++;
        if (o_flag !== 2'b00 || o_ivalid !== 1'b0) begin
            n_fail++; $display("FAIL fetch_c2_wait: flag=%b valid=%b want 00/0", o_flag, o_ivalid);
        end
        mc_done = 1; mc_read_data = 32'h00000013;
        tick();
        mc_done = 0;
        n_tests++;
        if (o_ivalid !== 1'b1 || o_inst !== 32'h13 || o_addr !== 0) begin
            n_fail++; $display("FAIL fetch_c3_valid: valid=%b inst=%h addr=%h want 1/00000013/0", o_ivalid, o_inst, o_addr);
        end
        if_req = 0;
        tick();
        n_tests++;
        if (o_ivalid !== 1'b0 || o_busy !== 1'b0 || o_inst !== 32'h13) begin
            n_fail++; $display("FAIL fetch_c4_idle: valid=%b busy=%b inst=%h want 0/0/00000013", o_ivalid, o_busy, o_inst);
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0]  fl [3];
        logic [31:0] ad [3], wd [3], dt [3];
        logic [2:0]  pl [3];
        logic [1:0]  e_fl [3] = '{2'b10, 2'b01, 2'b01};
        logic [31:0] e_ad [3] = '{32'h200, 32'h300, 32'h400};
        logic [2:0]  e_pl [3] = '{3'b100, 3'b010, 3'b001};
        sel = 0;
        apply_reset();
        mem_wreq = 1; mem_waddr = 32'h200; mem_wdata = 32'h11111111; mem_wmask = 4'hF;
        mem_rreq = 1; mem_raddr = 32'h300;
        if_req = 1;   if_addr = 32'h400;
        serve(32'h0, 1, fl[0], ad[0], wd[0], pl[0], dt[0]);
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy=%b want 0", o_busy); end
        serve(32'h33333333, 1, fl[1], ad[1], wd[1], pl[1], dt[1]);
        serve(32'h44444444, 1, fl[2], ad[2], wd[2], pl[2], dt[2]);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (fl[i] !== e_fl[i] || ad[i] !== e_ad[i] || pl[i] !== e_pl[i]) begin
                n_fail++;
                $display("FAIL fixed_grant%0d: flag=%b addr=%h pulse=%b want %b/%h/%b", i, fl[i], ad[i], pl[i], e_fl[i], e_ad[i], e_pl[i]);
            end
        end
        n_tests++;
        if (wd[0] !== 32'h11111111 || dt[1] !== 32'h33333333 || dt[2] !== 32'h44444444) begin
            n_fail++; $display("FAIL fixed_data: wdata=%h rdata=%h inst=%h want 11111111/33333333/44444444", wd[0], dt[1], dt[2]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  fl;
        logic [31:0] ad, wd, dt;
        logic [2:0]  pl;
        logic [1:0]  e_fl [4] = '{2'b01, 2'b01, 2'b10, 2'b01};
        logic [31:0] e_ad [4] = '{32'h400, 32'h300, 32'h200, 32'h400};
        logic [2:0]  e_pl [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        sel = 1;
        apply_reset();
        mem_wreq = 1; mem_waddr = 32'h200; mem_rreq = 1; mem_raddr = 32'h300; if_req = 1; if_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            serve(32'h55 + i, 0, fl, ad, wd, pl, dt);
            n_tests++;
            if (fl !== e_fl[i] || ad !== e_ad[i] || pl !== e_pl[i]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: flag=%b addr=%h pulse=%b want %b/%h/%b", i, fl, ad, pl, e_fl[i], e_ad[i], e_pl[i]);
            end
        end
        if_req = 0; mem_rreq = 0; mem_wreq = 0;
        sel = 0;
    endtask

    task automatic test_busy_stall();
        int bad = 0;
        apply_reset();
        mem_wreq = 1; mem_waddr = 32'h500; mem_wmask = 4'b0101; mem_wdata = 32'hAABBCCDD; mc_busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_flag !== 2'b00 || o_wmsk !== 4'b0101 || o_wdat !== 32'hAABBCCDD || o_addr !== 32'h500) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d bad cycles, last flag=%b mask=%b, want 00/0101", bad, o_flag, o_wmsk); end
        mc_busy = 0;
        #1;
        n_tests++;
        if (o_flag !== 2'b10 || o_wmsk !== 4'b0101) begin
            n_fail++; $display("FAIL stall_issue: flag=%b mask=%b want 10/0101", o_flag, o_wmsk);
        end
        tick();
        n_tests++;
        if (o_flag !== 2'b00 || o_wmsk !== 4'b0101 || o_wdone !== 1'b0) begin
            n_fail++; $display("FAIL stall_wait: flag=%b mask=%b wdone=%b want 00/0101/0", o_flag, o_wmsk, o_wdone);
        end
        mc_done = 1;
        tick();
        mc_done = 0;
        n_tests++;
        if (o_wdone !== 1'b1 || o_wmsk !== 4'b0 || o_rvalid !== 1'b0 || o_ivalid !== 1'b0) begin
            n_fail++; $display("FAIL stall_wdone: wdone=%b mask=%b rvalid=%b ivalid=%b want 1/0/0/0", o_wdone, o_wmsk, o_rvalid, o_ivalid);
        end
        mem_wreq = 0;
        tick();
        n_tests++;
        if (o_wdone !== 1'b0) begin n_fail++; $display("FAIL stall_wdone_once: wdone=%b want 0", o_wdone); end
    endtask

    task automatic test_reset_in_wait();
        logic [1:0]  fl;
        logic [31:0] ad, wd, dt;
        logic [2:0]  pl;
        apply_reset();
        mem_rreq = 1; mem_raddr = 32'h600;
        tick();
        tick();
        rst = 1;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_addr !== 0 || o_flag !== 2'b00) begin
            n_fail++; $display("FAIL async_reset: busy=%b addr=%h flag=%b want 0/0/00", o_busy, o_addr, o_flag);
        end
        mem_rreq = 0;
        tick();
        rst = 0;
        mc_done = 1; mc_read_data = 32'hDEAD;
        tick();
        mc_done = 0;
        tick();
        n_tests++;
        if (o_rvalid !== 1'b0 || o_ivalid !== 1'b0 || o_busy !== 1'b0 || o_rdata !== 0) begin
            n_fail++; $display("FAIL stale_done: rvalid=%b busy=%b rdata=%h want 0/0/0", o_rvalid, o_busy, o_rdata);
        end
        if_req = 1; if_addr = 32'h700;
        serve(32'h1234, 1, fl, ad, wd, pl, dt);
        n_tests++;
        if (fl !== 2'b01 || ad !== 32'h700 || pl !== 3'b001 || dt !== 32'h1234) begin
            n_fail++; $display("FAIL after_reset_fetch: flag=%b addr=%h pulse=%b inst=%h want 01/700/001/1234", fl, ad, pl, dt);
        end
    endtask

    task automatic test_drop_requests();
        int pulses = 0;
        apply_reset();
        if_req = 1; if_addr = 32'h900;
        #2;
        if_req = 0;
        tick();
        n_tests++;
        if (o_busy !== 1'b0 || o_flag !== 2'b00) begin
            n_fail++; $display("FAIL drop_before_grant: busy=%b flag=%b want 0/00", o_busy, o_flag);
        end
        mc_done = 1;
        tick();
        mc_done = 0;
        n_tests++;
        if (o_ivalid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_spurious_done: valid=%b busy=%b want 0/0", o_ivalid, o_busy);
        end
        if_req = 1; if_addr = 32'h800;
        tick();
        if_req = 0;
        n_tests++;
        if (o_flag !== 2'b01 || o_addr !== 32'h800) begin
            n_fail++; $display("FAIL drop_after_grant_cmd: flag=%b addr=%h want 01/800", o_flag, o_addr);
        end
        tick();
        mc_done = 1; mc_read_data = 32'hCAFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            mc_done = 0;
            pulses += int'(o_ivalid);
        end
        n_tests++;
        if (pulses != 1 || o_inst !== 32'hCAFE || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_after_grant_pulse: pulses=%0d inst=%h busy=%b want 1/cafe/0", pulses, o_inst, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_fixed_priority();
        test_round_robin();
        test_busy_stall();
        test_reset_in_wait();
        test_drop_requests();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_arbiter.md
Name: mmu_arbiter

Overview:
Synthesizable successor to the behavioural simulation MMU. It arbitrates the instruction-fetch (IF) port and the data read/write (MEM) ports onto one memory-controller channel using a req/busy/done handshake. Each access is latched at grant and tracked by a 4-state FSM, and its result is returned as a one-cycle valid/done pulse. Data width and arbitration policy are parametrised, and the block sits between the pipeline's IF/MEM stages and the memory controller.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data/instruction width; must be a multiple of 8
MASK_W, DATA_W/8, byte-mask width (derived, not overridable)
RR_MODE, 0, 0 = fixed priority (MEM write > MEM read > IF); 1 = round-robin over the three sources

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address
if_valid  out  1  one-cycle pulse: if_inst valid
if_inst  out  DATA_W  fetched instruction, registered
mem_rreq  in  1  load request, held until mem_rvalid
mem_raddr  in  ADDR_W  load address
mem_rvalid  out  1  one-cycle pulse: mem_rdata valid
mem_rdata  out  DATA_W  load data, registered
mem_wreq  in  1  store request, held until mem_wdone
mem_waddr  in  ADDR_W  store address
mem_wmask  in  MASK_W  store byte enables
mem_wdata  in  DATA_W  store data
mem_wdone  out  1  one-cycle pulse: store completed
busy  out  1  arbiter occupied (state != IDLE)
mc_rw_flag  out  2  00 idle, 01 read, 10 write; 11 never driven
mc_addr  out  ADDR_W  controller address
mc_write_data  out  DATA_W  controller write data
mc_write_mask  out  MASK_W  controller byte mask
mc_read_data  in  DATA_W  controller read data, valid with mc_done
mc_busy  in  1  controller cannot accept a command
mc_done  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE; RR pointer=IF; all outputs 0, including if_inst/mem_rdata and the mc_* buses.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is high, grant one source, latch addr/wdata/wmask/owner, go to ISSUE. Otherwise stay in IDLE.
- RR_MODE=0: wreq beats rreq, and rreq beats if_req.
- RR_MODE=1: search starts at the pointer, order IF -> MEM read -> MEM write -> IF. After a grant the pointer moves to the source after the granted one.
- ISSUE with mc_busy=1: mc_rw_flag=00, stay in ISSUE, latched values held.
- ISSUE with mc_busy=0: drive mc_rw_flag (01 for read/fetch, 10 for write) for exactly this cycle, go to WAIT.
- mc_addr, mc_write_data and mc_write_mask carry the latched values in ISSUE and WAIT, and are 0 otherwise.
- WAIT: mc_rw_flag=00. On mc_done, capture mc_read_data into a data register (reads/fetch only) and go to RESP.
- RESP: pulse exactly one of if_valid/mem_rvalid/mem_wdone for one cycle, then go to IDLE. No new grant is made in RESP.
- Data outputs: if_inst and mem_rdata update only in RESP for their own owner and otherwise hold their last value.
- Minimum latency (mc_done the cycle after issue): req seen at cycle 0, command at cycle 1, done at cycle 2, valid at cycle 3. A back-to-back request is granted at cycle 4.
- Requester drops req after grant: the transaction still completes and the pulse is still emitted.
- Requester drops req before grant: nothing is issued.
- mc_done in IDLE/ISSUE/RESP (spurious or stale after reset) is ignored.
- Addresses pass through unmodified with no alignment enforcement. An all-zero mask is still issued as a write.
- Simultaneous wreq and rreq to the same address (RR_MODE=0): the write completes before the read is granted, so the read returns the new data.
- busy = (state != IDLE).

Test Plan:
- Single fetch, RR_MODE=0, mc_done one cycle after issue, if_addr=0x100, mc_read_data=0x00000013 -> mc_rw_flag=01 at cycle 1 only; if_valid pulses at cycle 3 with if_inst=0x00000013.
- All three requests together, RR_MODE=0 -> grant order write, read, fetch; mc_rw_flag sequence 10, 01, 01.
- All three requests held, RR_MODE=1 -> grants IF, read, write, IF, in that rotation.
- Store, wmask=4'b0101, wdata=0xAABBCCDD, mc_busy=1 for 3 cycles -> command held in ISSUE; mc_rw_flag=10 only in the first cycle mc_busy=0; mc_write_mask=0101; mem_wdone pulses one cycle after mc_done.
- rst asserted in WAIT, then mc_done arrives after release -> outputs 0 immediately on rst; the stale mc_done produces no valid pulse; the next request proceeds normally.
- if_req dropped the cycle after grant -> fetch still issued and if_valid still pulses once.
